// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - AXI-Stream bundle shared by the arbiter inputs and output
//
// Purpose : groups one stream's handshake and payload signals.
// Signals : tvalid/tready handshake, tdata (DATA_WIDTH), tkeep (1 bit),
//           tlast packet delimiter, tdest (DEST_WIDTH) routing index.
// Modports: master drives payload and tvalid and samples tready;
//           slave samples payload and tvalid and drives tready.
interface axis_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 2
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tkeep;
  logic                  tlast;
  logic [DEST_WIDTH-1:0] tdest;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    output tdest,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tdest,
    output tready
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - three-input round-robin AXI-Stream packet arbiter
//
// Purpose : merges s0/s1/s2 into m_axis one whole packet at a time, in
//           round-robin order, tagging every output beat with its source
//           index on m_axis.tdest so a downstream switch can route it back.
// Ports   : s_axis_aclk     clock, all logic on the rising edge
//           s_axis_aresetn  asynchronous active-low reset
//           s0/s1/s2_axis   slave streams (tdest on the inputs is ignored)
//           m_axis          merged master stream, fully registered
//           arb_en          1 = new grants allowed, 0 = finish packet then idle
//           grant           granted source 0..2, 3 when none
//           busy            1 while a packet is being forwarded
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 2
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  axis_rr_arbiter_if.slave         s0_axis,
  axis_rr_arbiter_if.slave         s1_axis,
  axis_rr_arbiter_if.slave         s2_axis,
  axis_rr_arbiter_if.master        m_axis,
  input  logic                     arb_en,
  output logic [1:0]               grant,
  output logic                     busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [1:0]            r_ptr;
  logic [1:0]            r_grant;

  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tkeep;
  logic                  r_m_tlast;
  logic [DEST_WIDTH-1:0] r_m_tdest;

  logic [2:0]            w_valid;
  logic                  w_any;
  logic [1:0]            w_pick;

  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_keep;
  logic                  w_sel_last;

  logic                  w_out_ready;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_end;
  logic [2:0]            w_tready;

  assign w_valid = {s2_axis.tvalid, s1_axis.tvalid, s0_axis.tvalid};
  assign w_any   = |w_valid;

  // First valid source starting at the round-robin pointer. The result is
  // only used when w_any is set, so the fall-through value is arbitrary.
  always_comb begin
    w_pick = 2'd0;
    case (r_ptr)
      2'd1: begin
        if (w_valid[1])      w_pick = 2'd1;
        else if (w_valid[2]) w_pick = 2'd2;
        else                 w_pick = 2'd0;
      end
      2'd2: begin
        if (w_valid[2])      w_pick = 2'd2;
        else if (w_valid[0]) w_pick = 2'd0;
        else                 w_pick = 2'd1;
      end
      default: begin
        if (w_valid[0])      w_pick = 2'd0;
        else if (w_valid[1]) w_pick = 2'd1;
        else                 w_pick = 2'd2;
      end
    endcase
  end

  // Payload of the granted source; grant 3 selects nothing.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = 1'b0;
    w_sel_last  = 1'b0;
    case (r_grant)
      2'd0: begin
        w_sel_valid = s0_axis.tvalid;
        w_sel_data  = s0_axis.tdata;
        w_sel_keep  = s0_axis.tkeep;
        w_sel_last  = s0_axis.tlast;
      end
      2'd1: begin
        w_sel_valid = s1_axis.tvalid;
        w_sel_data  = s1_axis.tdata;
        w_sel_keep  = s1_axis.tkeep;
        w_sel_last  = s1_axis.tlast;
      end
      2'd2: begin
        w_sel_valid = s2_axis.tvalid;
        w_sel_data  = s2_axis.tdata;
        w_sel_keep  = s2_axis.tkeep;
        w_sel_last  = s2_axis.tlast;
      end
      default: begin
        w_sel_valid = 1'b0;
      end
    endcase
  end

  // The output register can take a beat when it is empty or being drained
  // this cycle, which gives full throughput without a skid buffer.
  assign w_out_ready = m_axis.tready | ~r_m_tvalid;
  assign w_start     = (r_state == ST_IDLE) && arb_en && w_any;
  assign w_accept    = (r_state == ST_BUSY) && w_sel_valid && w_out_ready;
  assign w_end       = w_accept && w_sel_last;

  // State register.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. arb_en is only consulted in IDLE, so dropping it
  // mid-packet lets the current packet run to its tlast.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_end)   w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: only the granted source ever sees tready.
  always_comb begin
    w_tready = 3'b000;
    busy     = 1'b0;
    if (r_state == ST_BUSY) begin
      busy = 1'b1;
      case (r_grant)
        2'd0:    w_tready = {2'b00, w_out_ready};
        2'd1:    w_tready = {1'b0, w_out_ready, 1'b0};
        2'd2:    w_tready = {w_out_ready, 2'b00};
        default: w_tready = 3'b000;
      endcase
    end
  end

  // Grant and round-robin pointer. The pointer advances past the source
  // that just finished, so a source that keeps requesting yields its turn.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_grant <= GRANT_NONE;
      r_ptr   <= 2'd0;
    end else if (w_start) begin
      r_grant <= w_pick;
    end else if (w_end) begin
      r_grant <= GRANT_NONE;
      case (r_grant)
        2'd0:    r_ptr <= 2'd1;
        2'd1:    r_ptr <= 2'd2;
        default: r_ptr <= 2'd0;
      endcase
    end
  end

  // Output register. Payload fields keep their last value after a drain.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdest  <= '0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_data;
      r_m_tkeep  <= w_sel_keep;
      r_m_tlast  <= w_sel_last;
      r_m_tdest  <= DEST_WIDTH'(r_grant);
    end else if (r_m_tvalid && m_axis.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s0_axis.tready = w_tready[0];
  assign s1_axis.tready = w_tready[1];
  assign s2_axis.tready = w_tready[2];

  assign m_axis.tvalid  = r_m_tvalid;
  assign m_axis.tdata   = r_m_tdata;
  assign m_axis.tkeep   = r_m_tkeep;
  assign m_axis.tlast   = r_m_tlast;
  assign m_axis.tdest   = r_m_tdest;

  assign grant          = r_grant;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - self-checking bench for axis_rr_arbiter
module tb_axis_rr_arbiter;
  localparam int DW   = 8;
  localparam int DSTW = 2;

  typedef struct {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic [1:0] dest;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW)) s0_if ();
  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW)) s1_if ();
  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW)) s2_if ();
  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW)) m_if ();

  logic       arb_en;
  logic [1:0] grant;
  logic       busy;
  logic       s_valid [3];
  logic [7:0] s_data  [3];
  logic       s_last  [3];
  logic       m_ready;
  logic [2:0] s_ready;

  assign s0_if.tvalid = s_valid[0];
  assign s0_if.tdata  = s_data[0];
  assign s0_if.tkeep  = ~s_data[0][0];
  assign s0_if.tlast  = s_last[0];
  assign s0_if.tdest  = '0;
  assign s1_if.tvalid = s_valid[1];
  assign s1_if.tdata  = s_data[1];
  assign s1_if.tkeep  = ~s_data[1][0];
  assign s1_if.tlast  = s_last[1];
  assign s1_if.tdest  = '0;
  assign s2_if.tvalid = s_valid[2];
  assign s2_if.tdata  = s_data[2];
  assign s2_if.tkeep  = ~s_data[2][0];
  assign s2_if.tlast  = s_last[2];
  assign s2_if.tdest  = '0;
  assign m_if.tready  = m_ready;
  assign s_ready      = {s2_if.tready, s1_if.tready, s0_if.tready};

  axis_rr_arbiter #(.DATA_WIDTH(DW), .DEST_WIDTH(DSTW)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s0_axis        (s0_if),
    .s1_axis        (s1_if),
    .s2_axis        (s2_if),
    .m_axis         (m_if),
    .arb_en         (arb_en),
    .grant          (grant),
    .busy           (busy)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  beat_t expq [$];
  int    xq   [$];
  int    gq   [$];
  bit    sb_en = 1'b0;
  int    stall_cnt = 0;
  int    nwait;
  int    nbusy;
  bit    seen;
  bit    fin;
  bit    leak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int n, input logic [7:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d    = base + 8'(i);
      b.k    = ~b.d[0];
      b.l    = (i == n - 1);
      b.dest = 2'(src);
      expq.push_back(b);
    end
  endtask

  task automatic drive_pkt(input int src, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      int   w;
      logic acc;
      s_valid[src] = 1'b1;
      s_data[src]  = base + 8'(i);
      s_last[src]  = (i == n - 1);
      w   = 0;
      acc = 1'b0;
      while (!acc && w < 300) begin
        @(negedge clk);
        w++;
        acc = s_ready[src];
      end
      chk("src_accept_timeout", 32'(!acc), 0);
      @(posedge clk);
      #1;
    end
    s_valid[src] = 1'b0;
    s_last[src]  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_tvalid"}, 32'(m_if.tvalid), 0);
    chk({tag, "_m_tdata"},  32'(m_if.tdata), 0);
    chk({tag, "_m_tkeep"},  32'(m_if.tkeep), 0);
    chk({tag, "_m_tlast"},  32'(m_if.tlast), 0);
    chk({tag, "_m_tdest"},  32'(m_if.tdest), 0);
    chk({tag, "_s_tready"}, 32'(s_ready), 0);
    chk({tag, "_grant"},    32'(grant), 3);
    chk({tag, "_busy"},     32'(busy), 0);
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) s_valid[i] = 1'b0;
    m_ready = 1'b1;
    arb_en  = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy || m_if.tvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n >= 300), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Output monitor: scoreboard pop, stall stability and post-drain hold.
  initial begin
    bit         have_prev;
    bit         have_last;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_lastb;
    logic [1:0] prev_dest;
    logic [7:0] last_data;
    beat_t      b;
    have_prev = 1'b0;
    have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !sb_en) begin
        have_prev = 1'b0;
        have_last = 1'b0;
      end else begin
        if (have_prev && prev_stall) begin
          stall_cnt++;
          chk("stall_valid", 32'(m_if.tvalid), 1);
          chk("stall_data",  32'(m_if.tdata), 32'(prev_data));
          chk("stall_last",  32'(m_if.tlast), 32'(prev_lastb));
          chk("stall_dest",  32'(m_if.tdest), 32'(prev_dest));
        end
        if (m_if.tvalid && m_if.tready) begin
          if (expq.size() == 0) begin
            chk("unexpected_beat", 32'(m_if.tdata), 32'hFFFF);
          end else begin
            b = expq.pop_front();
            chk("beat_data", 32'(m_if.tdata), 32'(b.d));
            chk("beat_keep", 32'(m_if.tkeep), 32'(b.k));
            chk("beat_last", 32'(m_if.tlast), 32'(b.l));
            chk("beat_dest", 32'(m_if.tdest), 32'(b.dest));
          end
          xq.push_back(cyc);
          last_data = m_if.tdata;
          have_last = 1'b1;
        end else if (!m_if.tvalid && have_last) begin
          chk("idle_hold_data", 32'(m_if.tdata), 32'(last_data));
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        prev_lastb = m_if.tlast;
        prev_dest  = m_if.tdest;
        have_prev  = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = 8'h00;
      s_last[i]  = 1'b0;
    end
    m_ready = 1'b1;
    arb_en  = 1'b1;
    rst_n   = 1'b1;
    #2;
    apply_reset();
    sb_en = 1'b1;

    // Single source, arbitration latency.
    push_pkt(1, 3, 8'h10);
    fork
      drive_pkt(1, 3, 8'h10);
      begin
        @(negedge clk);
        chk("t1_idle_grant", 32'(grant), 3);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_tready", 32'(s_ready), 0);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_tready", 32'(s_ready), 32'b010);
        chk("t1_mvalid_early", 32'(m_if.tvalid), 0);
        @(negedge clk);
        chk("t1_mvalid", 32'(m_if.tvalid), 1);
        chk("t1_mdata", 32'(m_if.tdata), 32'h10);
      end
    join
    wait_drain("t1_drain");

    // Contention from reset: order 0,1,2,0,1,2 with one bubble per packet.
    sb_en = 1'b0;
    apply_reset();
    sb_en = 1'b1;
    xq.delete();
    gq.delete();
    push_pkt(0, 1, 8'hA0);
    push_pkt(1, 1, 8'hB0);
    push_pkt(2, 1, 8'hC0);
    push_pkt(0, 1, 8'hA1);
    push_pkt(1, 1, 8'hB1);
    push_pkt(2, 1, 8'hC1);
    fork
      begin drive_pkt(0, 1, 8'hA0); drive_pkt(0, 1, 8'hA1); end
      begin drive_pkt(1, 1, 8'hB0); drive_pkt(1, 1, 8'hB1); end
      begin drive_pkt(2, 1, 8'hC0); drive_pkt(2, 1, 8'hC1); end
      begin
        nwait = 0;
        while (gq.size() < 6 && nwait < 60) begin
          @(negedge clk);
          nwait++;
          if (busy) gq.push_back(int'(grant));
        end
      end
    join
    wait_drain("t2_drain");
    chk("t2_grant_count", 32'(gq.size()), 6);
    for (int i = 0; i < gq.size(); i++) chk("t2_rr_grant", 32'(gq[i]), 32'(i % 3));
    chk("t2_beat_count", 32'(xq.size()), 6);
    for (int i = 1; i < xq.size(); i++) chk("t2_bubble", 32'(xq[i] - xq[i-1]), 2);

    // Packet lock: s0 four beats while s1/s2 wait.
    push_pkt(0, 4, 8'h30);
    push_pkt(1, 1, 8'h40);
    push_pkt(2, 1, 8'h48);
    leak  = 1'b0;
    nbusy = 0;
    seen  = 1'b0;
    fin   = 1'b0;
    fork
      drive_pkt(0, 4, 8'h30);
      drive_pkt(1, 1, 8'h40);
      drive_pkt(2, 1, 8'h48);
      begin
        nwait = 0;
        while (!fin && nwait < 80) begin
          @(negedge clk);
          nwait++;
          if (busy && grant == 2'd0) begin
            seen = 1'b1;
            nbusy++;
            if (s_ready[1] || s_ready[2]) leak = 1'b1;
          end else if (seen) begin
            fin = 1'b1;
          end
        end
      end
    join
    wait_drain("t3_drain");
    chk("t3_lock_leak", 32'(leak), 0);
    chk("t3_lock_len", 32'(nbusy), 4);

    // Backpressure on a four-beat s2 packet.
    stall_cnt = 0;
    push_pkt(2, 4, 8'h80);
    fork
      drive_pkt(2, 4, 8'h80);
      begin
        for (int i = 0; i < 24; i++) begin
          m_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");
    chk("t4_stalls_seen", 32'(stall_cnt != 0), 1);

    // arb_en dropped mid-packet: packet completes, then holds idle.
    push_pkt(0, 4, 8'h50);
    push_pkt(1, 1, 8'h60);
    fork
      drive_pkt(0, 4, 8'h50);
      drive_pkt(1, 1, 8'h60);
      begin
        @(negedge clk);
        @(posedge clk);
        #1;
        arb_en = 1'b0;
        chk("t5_grant0", 32'(grant), 0);
        nwait = 0;
        while (busy && nwait < 60) begin
          @(negedge clk);
          nwait++;
        end
        chk("t5_finish_timeout", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t5_hold_grant", 32'(grant), 3);
          chk("t5_hold_busy", 32'(busy), 0);
          chk("t5_hold_tready", 32'(s_ready), 0);
        end
        @(posedge clk);
        #1;
        arb_en = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("t5_regrant", 32'(grant), 1);
        chk("t5_regrant_busy", 32'(busy), 1);
      end
    join
    wait_drain("t5_drain");

    // Reset mid-packet on s1 after two accepted beats.
    sb_en = 1'b0;
    s_valid[1] = 1'b1;
    s_data[1]  = 8'h70;
    s_last[1]  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    s_data[1] = 8'h71;
    @(posedge clk);
    #1;
    s_data[1] = 8'h72;
    #2;
    chk("t6_pre_mvalid", 32'(m_if.tvalid), 1);
    chk("t6_pre_mdata", 32'(m_if.tdata), 32'h71);
    chk("t6_pre_grant", 32'(grant), 1);
    rst_n = 1'b0;
    #1;
    check_reset("t6_async");
    s_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    sb_en = 1'b1;
    push_pkt(0, 1, 8'hA5);
    push_pkt(1, 1, 8'hB5);
    push_pkt(2, 1, 8'hC5);
    fork
      drive_pkt(0, 1, 8'hA5);
      drive_pkt(1, 1, 8'hB5);
      drive_pkt(2, 1, 8'hC5);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t6_first_grant", 32'(grant), 0);
      end
    join
    wait_drain("t6_drain");
    chk("sb_empty", 32'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
